// File: rtl/usb_arbiter.sv
// usb_arbiter: round-robin arbiter that lets two requesters share one drive bus.
// Each transaction goes through SETUP, HOLD and RESP. In SETUP the write strobe
// fires. HOLD lasts ACCESS_CYCLES cycles. At the end of HOLD the read data is
// sampled, and in RESP the owner receives a one-cycle ack.
module usb_arbiter #(
    parameter int unsigned BUSWIDTH      = 8,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_a,
    input  logic                wr_a,
    input  logic [BUSWIDTH-1:0] addr_a,
    input  logic [BUSWIDTH-1:0] wdata_a,
    output logic                ack_a,
    output logic [BUSWIDTH-1:0] rdata_a,
    input  logic                req_b,
    input  logic                wr_b,
    input  logic [BUSWIDTH-1:0] addr_b,
    input  logic [BUSWIDTH-1:0] wdata_b,
    output logic                ack_b,
    output logic [BUSWIDTH-1:0] rdata_b,
    output logic [BUSWIDTH-1:0] drv_read_addr,
    output logic [BUSWIDTH-1:0] drv_write_addr,
    output logic [BUSWIDTH-1:0] drv_write_data,
    output logic                drv_we,
    input  logic [BUSWIDTH-1:0] drv_data,
    output logic                busy,
    output logic                grant_b
);

    typedef enum logic [1:0] {IDLE, SETUP, HOLD, RESP} state_e;

    state_e                state_q;
    logic                  last_b_q;
    logic [BUSWIDTH-1:0]   cmd_addr_q;
    logic [BUSWIDTH-1:0]   cmd_wdata_q;
    logic [3:0]            cnt_q;
    logic                  ack_a_q;
    logic                  ack_b_q;
    logic [BUSWIDTH-1:0]   rdata_a_q;
    logic [BUSWIDTH-1:0]   rdata_b_q;
    logic                  drv_we_q;
    logic                  busy_q;
    logic                  grant_b_q;

    logic                  win_b_d;
    logic                  win_wr_d;
    logic [BUSWIDTH-1:0]   win_addr_d;
    logic [BUSWIDTH-1:0]   win_wdata_d;

    // Pick the winner. When both requesters are active, the one not served last wins.
    always_comb begin
        win_b_d     = 1'b0;
        win_wr_d    = 1'b0;
        win_addr_d  = '0;
        win_wdata_d = '0;
        if (req_a && req_b) begin
            win_b_d = ~last_b_q;
        end else begin
            win_b_d = req_b;
        end
        if (win_b_d) begin
            win_wr_d    = wr_b;
            win_addr_d  = addr_b;
            win_wdata_d = wdata_b;
        end else begin
            win_wr_d    = wr_a;
            win_addr_d  = addr_a;
            win_wdata_d = wdata_a;
        end
    end

    // Transaction FSM. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= '0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            drv_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            grant_b_q   <= 1'b0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        state_q     <= SETUP;
                        grant_b_q   <= win_b_d;
                        last_b_q    <= win_b_d;
                        cmd_addr_q  <= win_addr_d;
                        cmd_wdata_q <= win_wdata_d;
                        // drv_we_q holds the latched wr for SETUP only, which yields a single strobe cycle
                        drv_we_q    <= win_wr_d;
                        busy_q      <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q  <= HOLD;
                    drv_we_q <= 1'b0;
                    cnt_q    <= 4'(ACCESS_CYCLES);
                end
                HOLD: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        if (grant_b_q) begin
                            rdata_b_q <= drv_data;
                            ack_b_q   <= 1'b1;
                        end else begin
                            rdata_a_q <= drv_data;
                            ack_a_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    drv_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack_a          = ack_a_q;
    assign ack_b          = ack_b_q;
    assign rdata_a        = rdata_a_q;
    assign rdata_b        = rdata_b_q;
    assign drv_read_addr  = cmd_addr_q;
    assign drv_write_addr = cmd_addr_q;
    assign drv_write_data = cmd_wdata_q;
    assign drv_we         = drv_we_q;
    assign busy           = busy_q;
    assign grant_b        = grant_b_q;

endmodule

// File: tb/tb_usb_arbiter.sv
// Directed testbench for usb_arbiter. It drives an ACCESS_CYCLES=2 instance and an
// ACCESS_CYCLES=1 instance. Each instance talks to a small drive memory model
// preloaded with mem[i] = i.
module tb_usb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;

    logic       req_a, wr_a, req_b, wr_b;
    logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
    logic       ack_a, ack_b, drv_we, busy, grant_b;
    logic [7:0] rdata_a, rdata_b, drv_read_addr, drv_write_addr, drv_write_data, drv_data;

    logic       req_a1;
    logic [7:0] addr_a1;
    logic       ack_a1, ack_b1, drv_we1, busy1, grant_b1;
    logic [7:0] rdata_a1, rdata_b1, rd_addr1, wr_addr1, wr_data1, drv_data1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       exp_b;

    always #5 clk = ~clk;

    usb_arbiter #(.BUSWIDTH(8), .ACCESS_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .drv_read_addr(drv_read_addr), .drv_write_addr(drv_write_addr),
        .drv_write_data(drv_write_data), .drv_we(drv_we), .drv_data(drv_data),
        .busy(busy), .grant_b(grant_b)
    );

    usb_arbiter #(.BUSWIDTH(8), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a1), .wr_a(1'b0), .addr_a(addr_a1), .wdata_a(8'h00),
        .ack_a(ack_a1), .rdata_a(rdata_a1),
        .req_b(1'b0), .wr_b(1'b0), .addr_b(8'h00), .wdata_b(8'h00),
        .ack_b(ack_b1), .rdata_b(rdata_b1),
        .drv_read_addr(rd_addr1), .drv_write_addr(wr_addr1),
        .drv_write_data(wr_data1), .drv_we(drv_we1), .drv_data(drv_data1),
        .busy(busy1), .grant_b(grant_b1)
    );

    assign drv_data  = mem0[drv_read_addr];
    assign drv_data1 = mem1[rd_addr1];

    always @(posedge clk) begin
        if (drv_we)  mem0[drv_write_addr] <= drv_write_data;
        if (drv_we1) mem1[wr_addr1]       <= wr_data1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b0; wr_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
        req_b = 1'b0; wr_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;
        req_a1 = 1'b0; addr_a1 = 8'h00;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (drv_we !== 1'b0) begin errors++; $display("FAIL reset_drv_we: got %b expected 0", drv_we); end
        next_cycle();
        next_cycle();
        checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL reset_ack_a: got %b expected 0", ack_a); end
        checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL reset_ack_b: got %b expected 0", ack_b); end
        checks++; if (grant_b !== 1'b0) begin errors++; $display("FAIL reset_grant_b: got %b expected 0", grant_b); end
        checks++; if (rdata_a !== 8'h00) begin errors++; $display("FAIL reset_rdata_a: got %h expected 00", rdata_a); end
        checks++; if (rdata_b !== 8'h00) begin errors++; $display("FAIL reset_rdata_b: got %h expected 00", rdata_b); end
        checks++; if (drv_read_addr !== 8'h00) begin errors++; $display("FAIL reset_rd_addr: got %h expected 00", drv_read_addr); end
        checks++; if (drv_write_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", drv_write_addr); end
        checks++; if (drv_write_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", drv_write_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        req_a = 1'b1; wr_a = 1'b0; addr_a = 8'h05;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            exp_b = (k == 4);
            checks++; if (ack_a !== exp_b) begin errors++; $display("FAIL read_ack_a c%0d: got %b expected %b", k, ack_a, exp_b); end
            checks++; if (drv_we !== 1'b0) begin errors++; $display("FAIL read_drv_we c%0d: got %b expected 0", k, drv_we); end
            if (k == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b expected 1", busy); end
                checks++; if (grant_b !== 1'b0) begin errors++; $display("FAIL read_grant: got %b expected 0", grant_b); end
                req_a = 1'b0;
            end
        end
        checks++; if (rdata_a !== 8'h05) begin errors++; $display("FAIL read_rdata_a: got %h expected 05", rdata_a); end
    endtask

    task automatic test_single_write();
        req_b = 1'b1; wr_b = 1'b1; addr_b = 8'h10; wdata_b = 8'hA5;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            exp_b = (k == 1);
            checks++; if (drv_we !== exp_b) begin errors++; $display("FAIL write_drv_we c%0d: got %b expected %b", k, drv_we, exp_b); end
            exp_b = (k == 4);
            checks++; if (ack_b !== exp_b) begin errors++; $display("FAIL write_ack_b c%0d: got %b expected %b", k, ack_b, exp_b); end
            checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL write_ack_a c%0d: got %b expected 0", k, ack_a); end
            if (k == 1) begin
                checks++; if (drv_write_addr !== 8'h10) begin errors++; $display("FAIL write_addr: got %h expected 10", drv_write_addr); end
                checks++; if (drv_write_data !== 8'hA5) begin errors++; $display("FAIL write_data: got %h expected a5", drv_write_data); end
                checks++; if (grant_b !== 1'b1) begin errors++; $display("FAIL write_grant: got %b expected 1", grant_b); end
                req_b = 1'b0; wr_b = 1'b0;
            end
        end
        checks++; if (rdata_b !== 8'hA5) begin errors++; $display("FAIL write_rdata_b: got %h expected a5", rdata_b); end
        checks++; if (rdata_a !== 8'h05) begin errors++; $display("FAIL write_rdata_a_kept: got %h expected 05", rdata_a); end
        req_a = 1'b1; wr_a = 1'b0; addr_a = 8'h10;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            exp_b = (k == 4);
            checks++; if (ack_a !== exp_b) begin errors++; $display("FAIL readback_ack_a c%0d: got %b expected %b", k, ack_a, exp_b); end
            if (k == 1) req_a = 1'b0;
        end
        checks++; if (rdata_a !== 8'hA5) begin errors++; $display("FAIL readback_rdata_a: got %h expected a5", rdata_a); end
    endtask

    task automatic test_simultaneous();
        rst_n = 1'b0;
        next_cycle();
        req_a = 1'b1; wr_a = 1'b0; addr_a = 8'h03;
        req_b = 1'b1; wr_b = 1'b0; addr_b = 8'h04;
        next_cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            next_cycle();
            exp_b = (k == 4) || (k == 14);
            checks++; if (ack_a !== exp_b) begin errors++; $display("FAIL rr_ack_a c%0d: got %b expected %b", k, ack_a, exp_b); end
            exp_b = (k == 9);
            checks++; if (ack_b !== exp_b) begin errors++; $display("FAIL rr_ack_b c%0d: got %b expected %b", k, ack_b, exp_b); end
            if (k == 1 || k == 6 || k == 11) begin
                exp_b = (k == 6);
                checks++; if (grant_b !== exp_b) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", k, grant_b, exp_b); end
            end
            if (k == 15) begin
                req_a = 1'b0; req_b = 1'b0;
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy: got %b expected 0", busy); end
        checks++; if (rdata_a !== 8'h03) begin errors++; $display("FAIL rr_rdata_a: got %h expected 03", rdata_a); end
        checks++; if (rdata_b !== 8'h04) begin errors++; $display("FAIL rr_rdata_b: got %h expected 04", rdata_b); end
    endtask

    task automatic test_input_change();
        req_a = 1'b1; wr_a = 1'b0; addr_a = 8'h05;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k <= 4) begin
                checks++; if (drv_read_addr !== 8'h05) begin errors++; $display("FAIL chg_rd_addr c%0d: got %h expected 05", k, drv_read_addr); end
            end
            if (k == 1) req_a = 1'b0;
            if (k == 2) addr_a = 8'h07;
        end
        checks++; if (rdata_a !== 8'h05) begin errors++; $display("FAIL chg_rdata_a: got %h expected 05", rdata_a); end
    endtask

    task automatic test_reset_mid_write();
        req_a = 1'b1; wr_a = 1'b1; addr_a = 8'h20; wdata_a = 8'h5A;
        next_cycle();
        req_a = 1'b0; wr_a = 1'b0;
        checks++; if (drv_we !== 1'b1) begin errors++; $display("FAIL rst_setup_we: got %b expected 1", drv_we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (drv_we !== 1'b0) begin errors++; $display("FAIL rst_async_we: got %b expected 0", drv_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
        checks++; if (rdata_a !== 8'h00) begin errors++; $display("FAIL rst_async_rdata_a: got %h expected 00", rdata_a); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL rst_no_ack c%0d: got %b expected 0", k, ack_a); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_resume c%0d: got %b expected 0", k, busy); end
        end
        checks++; if (mem0[32] !== 8'h20) begin errors++; $display("FAIL rst_no_write: got %h expected 20", mem0[32]); end
        req_a = 1'b1; wr_a = 1'b0; addr_a = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            exp_b = (k == 4);
            checks++; if (ack_a !== exp_b) begin errors++; $display("FAIL rst_after_ack c%0d: got %b expected %b", k, ack_a, exp_b); end
            if (k == 1) req_a = 1'b0;
        end
        checks++; if (rdata_a !== 8'h00) begin errors++; $display("FAIL rst_after_rdata: got %h expected 00", rdata_a); end
    endtask

    task automatic test_access_cycles_1();
        req_a1 = 1'b1; addr_a1 = 8'h09;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            exp_b = (k == 3);
            checks++; if (ack_a1 !== exp_b) begin errors++; $display("FAIL ac1_ack_a c%0d: got %b expected %b", k, ack_a1, exp_b); end
            exp_b = (k <= 3);
            checks++; if (busy1 !== exp_b) begin errors++; $display("FAIL ac1_busy c%0d: got %b expected %b", k, busy1, exp_b); end
            if (k == 1) req_a1 = 1'b0;
        end
        checks++; if (rdata_a1 !== 8'h09) begin errors++; $display("FAIL ac1_rdata_a: got %h expected 09", rdata_a1); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'(i);
            mem1[i] = 8'(i);
        end
        test_reset();
        test_single_read();
        test_single_write();
        test_simultaneous();
        test_input_change();
        test_reset_mid_write();
        test_access_cycles_1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
